mem_bus_master: RTL and testbench

Bus initiator for the 16x8 single-port CPU RAM. It accepts read and write requests on a valid/ready interface from the control unit and generates the RAM's address, read_enable and write_enable strobes. It drives the shared bidirectional data bus for writes and captures it on reads. It sits between the CPU sequencer and the RAM, and is the only driver of the RAM side of the bus apart from the RAM itself.

---
 rtl/mem_bus_pkg.sv | 25 ++
 rtl/mem_bus_iobuf.sv | 16 +
 rtl/mem_bus_master.sv | 180 ++++++++++++++++++
 tb/tb_mem_bus_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared widths, FSM state type and latency constants for the
// RAM bus initiator (mem_bus_master) and its pad buffer.
package mem_bus_pkg;

  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 8;

  // Cycles from the accepting edge to the edge where rsp_valid is first seen.
  localparam int RD_LAT      = 3;
  localparam int WR_LAT      = 2;
  localparam int WR_TURN_LAT = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    TURN    = 3'd4
  } state_e;

  function automatic logic is_rd_state(input state_e st);
    return (st == RD_ADDR) || (st == RD_DATA);
  endfunction

endpackage

// File: rtl/mem_bus_iobuf.sv
// mem_bus_iobuf: tristate pad driver for the shared RAM data bus.
// Drives pad with dout while oe is high, releases it to Z otherwise;
// din always reflects the resolved pad value.
module mem_bus_iobuf #(
  parameter int W = 8
) (
  input  logic         oe,
  input  logic [W-1:0] dout,
  output logic [W-1:0] din,
  inout  wire  [W-1:0] pad
);

  assign pad = oe ? dout : {W{1'bz}};
  assign din = pad;

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: valid/ready bus initiator for the 16x8 single-port RAM.
// Reads take RD_ADDR (RAM loads its output buffer) then RD_DATA (capture);
// writes drive address, data and write strobe for one cycle in WR.
// Optional build macro MEM_BUS_TURNAROUND_EN: a write accepted right after a
// read completes passes through a one-cycle TURN state with strobes low and
// the bus released, so RAM and master never drive mem_data back to back.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request, strobes low, bus released
// RD_ADDR | address + read strobe out, RAM loads its output buffer
// RD_DATA | read strobe held, RAM drives bus, captured at next edge
// WR      | address + write strobe + data out, RAM commits at next edge
// TURN    | dead cycle between a read and a write (macro builds only)
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_is_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  inout  wire  [DATA_W-1:0] mem_data
);

  state_e r_state;
  state_e w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rsp_valid;
  logic              r_rsp_is_write;

  logic              w_accept;
  logic              w_capture;
  logic              w_rsp_done;
  logic              w_rsp_wr;
  logic              w_oe;
  logic [DATA_W-1:0] w_din;

  // Strobes and bus enable come straight from the state register so they
  // cannot glitch and drop asynchronously on reset.
  assign req_ready        = (r_state == IDLE);
  assign busy             = (r_state != IDLE);
  assign mem_read_enable  = is_rd_state(r_state);
  assign mem_write_enable = (r_state == WR);
  assign w_oe             = (r_state == WR);

  assign mem_address  = r_mem_addr;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_is_write = r_rsp_is_write;
  assign rsp_rdata    = r_rdata;

  mem_bus_iobuf #(
    .W (DATA_W)
  ) u_iobuf (
    .oe   (w_oe),
    .dout (r_wdata),
    .din  (w_din),
    .pad  (mem_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the per-state datapath controls.
  always_comb begin
    w_state_nxt    = r_state;
    w_mem_addr_nxt = r_mem_addr;
    w_accept       = 1'b0;
    w_capture      = 1'b0;
    w_rsp_done     = 1'b0;
    w_rsp_wr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (!req_write) begin
            w_state_nxt    = RD_ADDR;
            w_mem_addr_nxt = req_addr;
          end else begin
`ifdef MEM_BUS_TURNAROUND_EN
            // r_rsp_valid && !r_rsp_is_write marks the cycle right after a
            // read finished; the RAM may still be releasing the bus.
            if (r_rsp_valid && !r_rsp_is_write) begin
              w_state_nxt = TURN;
            end else begin
              w_state_nxt    = WR;
              w_mem_addr_nxt = req_addr;
            end
`else
            w_state_nxt    = WR;
            w_mem_addr_nxt = req_addr;
`endif
          end
        end
      end
      RD_ADDR: begin
        w_state_nxt = RD_DATA;
      end
      RD_DATA: begin
        w_state_nxt = IDLE;
        w_capture   = 1'b1;
        w_rsp_done  = 1'b1;
      end
      WR: begin
        w_state_nxt = IDLE;
        w_rsp_done  = 1'b1;
        w_rsp_wr    = 1'b1;
      end
      TURN: begin
        // Address is only presented once the write strobe goes up.
        w_state_nxt    = WR;
        w_mem_addr_nxt = r_addr;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request latch: address and write data captured on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // RAM address register: changes only when entering RD_ADDR or WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr <= '0;
    end else begin
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  // Response: one-cycle completion pulse, read data held until next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid    <= 1'b0;
      r_rsp_is_write <= 1'b0;
      r_rdata        <= '0;
    end else begin
      r_rsp_valid <= w_rsp_done;
      if (w_rsp_done) begin
        r_rsp_is_write <= w_rsp_wr;
      end
      if (w_capture) begin
        r_rdata <= w_din;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed bench for mem_bus_master with a behavioural
// 16x8 RAM on the shared data bus. Expected values are hand-computed.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;

`ifdef MEM_BUS_TURNAROUND_EN
  localparam int EXP_RW_LAT  = 3;
  localparam int EXP_RW_TURN = 1;
`else
  localparam int EXP_RW_LAT  = 2;
  localparam int EXP_RW_TURN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_is_write;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [AW-1:0] mem_address;
  logic          mem_read_enable;
  logic          mem_write_enable;
  wire  [DW-1:0] mem_data;

  int n_cmp = 0;
  int n_mis = 0;
  int n_overlap = 0;

  always #5 clk = ~clk;

  mem_bus_master dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_is_write     (rsp_is_write),
    .rsp_rdata        (rsp_rdata),
    .busy             (busy),
    .mem_address      (mem_address),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_data         (mem_data)
  );

  // Behavioural RAM: output buffer loads on a read-strobe edge, drives the
  // bus while the read strobe is high, commits writes on the edge.
  logic [DW-1:0] ram [16];
  logic [DW-1:0] ram_obuf;

  always @(posedge clk) begin
    if (mem_read_enable)  ram_obuf <= ram[mem_address];
    if (mem_write_enable) ram[mem_address] <= mem_data;
  end

  assign mem_data = mem_read_enable ? ram_obuf : {DW{1'bz}};

  always @(negedge clk) begin
    if (mem_read_enable && mem_write_enable) n_overlap++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request and return #1 after the edge that accepted it.
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int k;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!req_ready) check_val("accept_timeout", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns in the rsp_valid cycle.
  task automatic wait_rsp(input string tag, input logic [DW-1:0] wdata,
                          output int lat, output int rd_cyc, output int wr_cyc,
                          output int turn_cyc, output logic [DW-1:0] rdata,
                          output logic is_wr);
    int k;
    k = 0; rd_cyc = 0; wr_cyc = 0; turn_cyc = 0;
    while (k < 10) begin
      if (mem_read_enable) rd_cyc++;
      if (mem_write_enable) begin
        wr_cyc++;
        check_val({tag, "_wdata"}, mem_data, wdata);
        check_val({tag, "_nox"}, $isunknown(mem_data), 0);
      end
      if (busy && !mem_read_enable && !mem_write_enable) begin
        turn_cyc++;
        check_val({tag, "_turn_bus_released"}, (mem_data === wdata), 0);
      end
      if (rsp_valid) break;
      @(posedge clk); #1;
      k++;
    end
    if (!rsp_valid) check_val({tag, "_rsp_timeout"}, rsp_valid, 1);
    lat   = k + 1;
    rdata = rsp_rdata;
    is_wr = rsp_is_write;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat, rdc, wrc, tc, pulses;
    logic [DW-1:0] rd;
    logic          iw;

    for (int i = 0; i < 16; i++) ram[i] = 8'h10 + 8'(i);
    ram[14]   = 8'hAA;
    ram[15]   = 8'h55;
    ram[13]   = 8'h00;
    ram[0]    = 8'h11;
    ram_obuf  = 8'h00;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state
    #12;
    check_val("rst_req_ready", req_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_ren", mem_read_enable, 0);
    check_val("rst_wen", mem_write_enable, 0);
    check_val("rst_addr", mem_address, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_is_write", rsp_is_write, 0);
    check_val("rst_rsp_rdata", rsp_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read 14
    issue(1'b0, 4'd14, 8'h00);
    check_val("rd14_addr", mem_address, 14);
    wait_rsp("rd14", 8'h00, lat, rdc, wrc, tc, rd, iw);
    check_val("rd14_lat", lat, RD_LAT);
    check_val("rd14_ren_cycles", rdc, 2);
    check_val("rd14_wen_cycles", wrc, 0);
    check_val("rd14_rdata", rd, 8'hAA);
    check_val("rd14_is_write", iw, 0);
    @(posedge clk); #1;
    check_val("rd14_pulse_one_cycle", rsp_valid, 0);
    check_val("rd14_rdata_hold", rsp_rdata, 8'hAA);

    // Write 0x3C to 13, then read back
    issue(1'b1, 4'd13, 8'h3C);
    check_val("wr13_addr", mem_address, 13);
    wait_rsp("wr13", 8'h3C, lat, rdc, wrc, tc, rd, iw);
    check_val("wr13_lat", lat, WR_LAT);
    check_val("wr13_wen_cycles", wrc, 1);
    check_val("wr13_ren_cycles", rdc, 0);
    check_val("wr13_is_write", iw, 1);
    check_val("wr13_rdata_unchanged", rd, 8'hAA);
    check_val("wr13_ram", ram[13], 8'h3C);
    @(posedge clk); #1;
    issue(1'b0, 4'd13, 8'h00);
    wait_rsp("rb13", 8'h00, lat, rdc, wrc, tc, rd, iw);
    check_val("rb13_lat", lat, RD_LAT);
    check_val("rb13_rdata", rd, 8'h3C);
    check_val("rb13_is_write", iw, 0);
    @(posedge clk); #1;

    // Back-to-back reads of 14 and 15 with req_valid held
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd14; req_wdata = 8'h00;
    @(posedge clk); #1;
    req_addr = 4'd15;
    wait_rsp("b2b_a", 8'h00, lat, rdc, wrc, tc, rd, iw);
    check_val("b2b_a_lat", lat, RD_LAT);
    check_val("b2b_a_rdata", rd, 8'hAA);
    check_val("b2b_ready_in_rsp_cycle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("b2b_second_accepted", busy, 1);
    check_val("b2b_second_addr", mem_address, 15);
    wait_rsp("b2b_b", 8'h00, lat, rdc, wrc, tc, rd, iw);
    check_val("b2b_b_lat", lat + 1, RD_LAT + 1);
    check_val("b2b_b_rdata", rd, 8'h55);
    @(posedge clk); #1;

    // Read then write to addr 0 accepted in the read's response cycle
    issue(1'b0, 4'd14, 8'h00);
    wait_rsp("rw_rd", 8'h00, lat, rdc, wrc, tc, rd, iw);
    check_val("rw_rd_rdata", rd, 8'hAA);
    issue(1'b1, 4'd0, 8'h96);
    wait_rsp("rw_wr", 8'h96, lat, rdc, wrc, tc, rd, iw);
    check_val("rw_wr_lat", lat, EXP_RW_LAT);
    check_val("rw_wr_turn_cycles", tc, EXP_RW_TURN);
    check_val("rw_wr_wen_cycles", wrc, 1);
    check_val("rw_wr_is_write", iw, 1);
    @(posedge clk); #1;
    issue(1'b0, 4'd0, 8'h00);
    wait_rsp("rb0", 8'h00, lat, rdc, wrc, tc, rd, iw);
    check_val("rb0_rdata", rd, 8'h96);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset during RD_DATA
    issue(1'b0, 4'd15, 8'h00);
    @(posedge clk); #1;
    check_val("rstrd_pre_ren", mem_read_enable, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rstrd_ren", mem_read_enable, 0);
    check_val("rstrd_wen", mem_write_enable, 0);
    check_val("rstrd_busy", busy, 0);
    check_val("rstrd_bus_released", (mem_data === 8'h55), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) pulses++;
      @(posedge clk); #1;
    end
    check_val("rstrd_no_rsp", pulses, 0);
    check_val("rstrd_rdata_cleared", rsp_rdata, 0);
    check_val("rstrd_ready", req_ready, 1);

    // Reset during WR, before the committing edge
    issue(1'b1, 4'd13, 8'h77);
    check_val("rstwr_pre_wen", mem_write_enable, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rstwr_wen", mem_write_enable, 0);
    check_val("rstwr_busy", busy, 0);
    check_val("rstwr_bus_released", (mem_data === 8'h77), 0);
    @(posedge clk); #1;
    check_val("rstwr_ram_unchanged", ram[13], 8'h3C);
    rst_n = 1'b1;
    check_val("rstwr_ready", req_ready, 1);
    @(posedge clk); #1;
    issue(1'b0, 4'd13, 8'h00);
    wait_rsp("rstwr_rb", 8'h00, lat, rdc, wrc, tc, rd, iw);
    check_val("rstwr_rb_rdata", rd, 8'h3C);
    @(posedge clk); #1;

    check_val("never_both_enables", n_overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
